// File: rtl/time_bcd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package : time_disp_pkg
// Shared types and constants for the minutes/seconds BCD decoder.
// Rev 1.0 : initial release
// ============================================================================
package time_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_BITS      = 6;
  localparam int MAX_VAL     = 59;
  localparam int ADD3_THRESH = 5;

endpackage : time_disp_pkg
`default_nettype wire

// File: rtl/time_bcd_decoder_dabble_field.sv
`default_nettype none
// ============================================================================
// Module  : dabble_field
// One field of the double-dabble converter: saturating load, scratch
// registers and the combinational add-3/shift step.
// Rev 1.0 : initial release
// ============================================================================
module dabble_field
  import time_disp_pkg::*;
#(
  parameter int N_BITS_P  = N_BITS,
  parameter int MAX_VAL_P = MAX_VAL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_shift,
  input  logic [N_BITS_P-1:0] i_bin,
  output logic [3:0]          o_tens_nxt,
  output logic [3:0]          o_units_nxt,
  output logic                o_oor
);

  logic [N_BITS_P-1:0] r_bin;
  logic [3:0]          r_tens;
  logic [3:0]          r_units;
  logic                r_oor;

  logic                w_sat;
  logic [3:0]          w_tens_adj;
  logic [3:0]          w_units_adj;
  logic [N_BITS_P-1:0] w_bin_nxt;

  assign w_sat = (i_bin > N_BITS_P'(MAX_VAL_P));

  // Tens never exceeds 5 after saturation, so its add-3 stays within 4 bits.
  assign w_tens_adj  = (r_tens  >= 4'(ADD3_THRESH)) ? r_tens  + 4'd3 : r_tens;
  assign w_units_adj = (r_units >= 4'(ADD3_THRESH)) ? r_units + 4'd3 : r_units;

  assign o_tens_nxt  = {w_tens_adj[2:0], w_units_adj[3]};
  assign o_units_nxt = {w_units_adj[2:0], r_bin[N_BITS_P-1]};
  assign w_bin_nxt   = {r_bin[N_BITS_P-2:0], 1'b0};
  assign o_oor       = r_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin   <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_oor   <= 1'b0;
    end else if (i_load) begin
      r_bin   <= w_sat ? N_BITS_P'(MAX_VAL_P) : i_bin;
      r_tens  <= '0;
      r_units <= '0;
      r_oor   <= w_sat;
    end else if (i_shift) begin
      r_bin   <= w_bin_nxt;
      r_tens  <= o_tens_nxt;
      r_units <= o_units_nxt;
    end
  end

endmodule : dabble_field
`default_nettype wire

// File: rtl/time_bcd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : time_bcd_decoder
// Multi-cycle binary-to-BCD converter for stopwatch minutes and seconds.
// Rev 1.0 : initial release
// ============================================================================
module time_bcd_decoder
  import time_disp_pkg::*;
#(
  parameter int N_BITS  = time_disp_pkg::N_BITS,
  parameter int MAX_VAL = time_disp_pkg::MAX_VAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] min_in,
  input  logic [N_BITS-1:0] sec_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        min_tens,
  output logic [3:0]        min_units,
  output logic [3:0]        sec_tens,
  output logic [3:0]        sec_units
);

  localparam int CW = $clog2(N_BITS + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_load;
  logic          w_shift;
  logic          w_last;

  logic [3:0]    w_min_tens_nxt;
  logic [3:0]    w_min_units_nxt;
  logic [3:0]    w_sec_tens_nxt;
  logic [3:0]    w_sec_units_nxt;
  logic          w_min_oor;
  logic          w_sec_oor;

  dabble_field #(
    .N_BITS_P  (N_BITS),
    .MAX_VAL_P (MAX_VAL)
  ) u_min (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_bin       (min_in),
    .o_tens_nxt  (w_min_tens_nxt),
    .o_units_nxt (w_min_units_nxt),
    .o_oor       (w_min_oor)
  );

  dabble_field #(
    .N_BITS_P  (N_BITS),
    .MAX_VAL_P (MAX_VAL)
  ) u_sec (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_bin       (sec_in),
    .o_tens_nxt  (w_sec_tens_nxt),
    .o_units_nxt (w_sec_units_nxt),
    .o_oor       (w_sec_oor)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CW'(N_BITS - 1)) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_cnt <= '0;
    else if (w_load)  r_cnt <= '0;
    else if (w_shift) r_cnt <= r_cnt + 1'b1;
  end

  // Digits capture the post-step scratch values on the final shift edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      min_tens  <= '0;
      min_units <= '0;
      sec_tens  <= '0;
      sec_units <= '0;
    end else begin
      busy <= (w_next != IDLE);
      done <= w_last;
      if (w_last) begin
        err       <= w_min_oor | w_sec_oor;
        min_tens  <= w_min_tens_nxt;
        min_units <= w_min_units_nxt;
        sec_tens  <= w_sec_tens_nxt;
        sec_units <= w_sec_units_nxt;
      end
    end
  end

endmodule : time_bcd_decoder
`default_nettype wire

// File: tb/tb_time_bcd_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_time_bcd_decoder
// Scoreboard bench for the minutes/seconds BCD decoder.
// Rev 1.0 : initial release
// ============================================================================
module tb_time_bcd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] min_tens;
  logic [3:0] min_units;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;

  int pass_cnt = 0;
  int total    = 0;

  logic [16:0] sb[$];

  always #5 clk = ~clk;

  time_bcd_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .min_tens  (min_tens),
    .min_units (min_units),
    .sec_tens  (sec_tens),
    .sec_units (sec_units)
  );

  // Reference: {min_tens, min_units, sec_tens, sec_units, err}
  function automatic logic [16:0] model(input int m, input int s);
    int ms, ss;
    logic e;
    e  = (m > 59) || (s > 59);
    ms = (m > 59) ? 59 : m;
    ss = (s > 59) ? 59 : s;
    return {4'(ms / 10), 4'(ms % 10), 4'(ss / 10), 4'(ss % 10), e};
  endfunction

  function automatic logic [16:0] observed();
    return {min_tens, min_units, sec_tens, sec_units, err};
  endfunction

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  // Drives start for one edge; returns at the negedge after the accept edge.
  task automatic kick(input int m, input int s);
    min_in = 6'(m);
    sec_in = 6'(s);
    start  = 1'b1;
    sb.push_back(model(m, s));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    min_in = '0;
    sec_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_ctrl: busy/done=%b want 00", {busy, done});
    else pass_cnt++;
    total++;
    if (observed() !== 17'h0) $display("FAIL reset_digits: got %h want 00000", observed());
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int c; bit seen; logic [16:0] exp;
    kick(0, 0);
    wait_done(12, c, seen);
    total++;
    if (!seen || c != 6) $display("FAIL zero_latency: seen=%0d cycles=%0d want 6", seen, c);
    else pass_cnt++;
    exp = sb.pop_front();
    total++;
    if (observed() !== exp) $display("FAIL zero_result: got %h want %h", observed(), exp);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_59_7();
    int c, b; bit seen; logic [16:0] exp;
    kick(59, 7);
    b = busy ? 1 : 0;
    c = 0; seen = 1'b0;
    while (c < 12) begin
      @(negedge clk);
      c++;
      if (busy) b++;
      if (done && !seen) begin
        seen = 1'b1;
        exp  = sb.pop_front();
        total++;
        if (observed() !== exp) $display("FAIL r59_7_result: got %h want %h", observed(), exp);
        else pass_cnt++;
      end
    end
    total++;
    if (!seen) $display("FAIL r59_7_timeout: done seen=%0d want 1", seen);
    else pass_cnt++;
    total++;
    if (b != 7) $display("FAIL r59_7_busy_len: got %0d want 7", b);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int c; bit seen; logic [16:0] exp;
    kick(63, 60);
    wait_done(12, c, seen);
    exp = sb.pop_front();
    total++;
    if (!seen || observed() !== exp) $display("FAIL sat_result: seen=%0d got %h want %h", seen, observed(), exp);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    kick(12, 34);
    wait_done(12, c, seen);
    exp = sb.pop_front();
    total++;
    if (!seen || observed() !== exp) $display("FAIL sat_next: seen=%0d got %h want %h", seen, observed(), exp);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int c, n; bit seen; logic [16:0] exp;
    kick(45, 30);
    @(negedge clk);
    min_in = 6'd10;
    sec_in = 6'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(12, c, seen);
    exp = sb.pop_front();
    total++;
    if (!seen || observed() !== exp) $display("FAIL ignore_result: seen=%0d got %h want %h", seen, observed(), exp);
    else pass_cnt++;
    n = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) n++;
    end
    total++;
    if (n != 0 || busy !== 1'b0) $display("FAIL ignore_extra: extra_done=%0d busy=%b want 0/0", n, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int c, n; bit seen; logic [16:0] exp;
    kick(33, 44);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, observed()} !== 19'h0) $display("FAIL midreset_clear: got %h want 00000", {busy, done, observed()});
    else pass_cnt++;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    total++;
    if (n != 0) $display("FAIL midreset_quiet: active cycles=%0d want 0", n);
    else pass_cnt++;
    kick(21, 58);
    wait_done(12, c, seen);
    exp = sb.pop_front();
    total++;
    if (!seen || observed() !== exp) $display("FAIL midreset_after: seen=%0d got %h want %h", seen, observed(), exp);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c; bit seen; logic [16:0] exp;
    min_in = 6'd0;
    sec_in = 6'd0;
    start  = 1'b1;
    sb.push_back(model(0, 0));
    for (int i = 0; i < 3600; i++) begin
      wait_done(12, c, seen);
      if (!seen) begin
        total++;
        $display("FAIL sweep_timeout: pair %0d no done", i);
        break;
      end
      exp = sb.pop_front();
      total++;
      if (observed() !== exp) $display("FAIL sweep_result: pair %0d got %h want %h", i, observed(), exp);
      else pass_cnt++;
      if (i > 0) begin
        total++;
        if (c != 8) $display("FAIL sweep_spacing: pair %0d got %0d want 8", i, c);
        else pass_cnt++;
      end
      if (i < 3599) begin
        min_in = 6'((i + 1) / 60);
        sec_in = 6'((i + 1) % 60);
        sb.push_back(model((i + 1) / 60, (i + 1) % 60));
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) $display("FAIL sweep_leftover: %0d entries want 0", sb.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_59_7();
    test_saturate();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule : tb_time_bcd_decoder
`default_nettype wire
